// File: rtl/serial_alu_seq_pkg.sv
// Shared definitions for the bit-serial ALU sequencer: opcodes, FSM states
// and opcode classification helpers.
package serial_alu_seq_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_ADDC = 4'h1;
  localparam logic [3:0] OP_XOR  = 4'h2;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_RUN  = 2'd1,
    SEQ_DONE = 2'd2
  } seq_state_t;

  function automatic logic op_legal(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_ADDC) || (op == OP_XOR);
  endfunction

  // ADD and ADDC produce a carry; XOR leaves the carry flag alone.
  function automatic logic op_is_arith(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_ADDC);
  endfunction

endpackage

// File: rtl/serial_alu_seq_alu.sv
// 1-bit ALU slice: full adder for ADD/ADDC, plain XOR otherwise.
module serial_alu_seq_alu
  import serial_alu_seq_pkg::*;
(
  input  logic       op_a,
  input  logic       op_b,
  input  logic       cin,
  input  logic [3:0] opcode,
  output logic       result,
  output logic       cout
);

  always_comb begin
    result = 1'b0;
    cout   = 1'b0;
    case (opcode)
      OP_ADD, OP_ADDC: begin
        result = op_a ^ op_b ^ cin;
        cout   = (op_a & op_b) | (op_a & cin) | (op_b & cin);
      end
      OP_XOR: begin
        result = op_a ^ op_b;
      end
      default: begin
        result = 1'b0;
        cout   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/serial_alu_seq.sv
// Bit-serial WIDTH-bit ADD/ADDC/XOR sequencer, LSB first, one bit per clock.
// Optional zero/ovf flag outputs are enabled by defining SERIAL_ALU_FLAGS_EN.
module serial_alu_seq
  import serial_alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
`ifdef SERIAL_ALU_FLAGS_EN
  output logic             zero,
  output logic             ovf,
`endif
  output logic             illegal
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  seq_state_t       state_reg, state_next;
  logic [WIDTH-1:0] a_sh_reg, b_sh_reg, r_sh_reg, r_sh_next;
  logic [WIDTH-1:0] result_reg;
  logic [3:0]       op_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             cbit_reg;
  logic             carry_reg;
  logic             illegal_reg;
  logic             alu_res, alu_cout;
  logic             can_start, accept, illegal_start, last_bit;

  assign can_start     = (state_reg != SEQ_RUN);
  assign accept        = start && can_start && op_legal(opcode);
  assign illegal_start = start && can_start && !op_legal(opcode);
  assign last_bit      = (cnt_reg == CNT_W'(WIDTH - 1));

  serial_alu_seq_alu u_alu (
    .op_a   (a_sh_reg[0]),
    .op_b   (b_sh_reg[0]),
    .cin    (cbit_reg),
    .opcode (op_reg),
    .result (alu_res),
    .cout   (alu_cout)
  );

  // New result bits enter at the MSB so the LSB-first stream lands in place.
  generate
    if (WIDTH == 1) begin : g_r_narrow
      assign r_sh_next = alu_res;
    end else begin : g_r_wide
      assign r_sh_next = {alu_res, r_sh_reg[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= SEQ_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      SEQ_IDLE: state_next = accept ? SEQ_RUN : SEQ_IDLE;
      SEQ_RUN:  state_next = last_bit ? SEQ_DONE : SEQ_RUN;
      SEQ_DONE: state_next = accept ? SEQ_RUN : SEQ_IDLE;
      default:  state_next = SEQ_IDLE;
    endcase
  end

  always_comb begin
    ready = (state_reg == SEQ_IDLE) || (state_reg == SEQ_DONE);
    done  = (state_reg == SEQ_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_reg    <= '0;
      b_sh_reg    <= '0;
      r_sh_reg    <= '0;
      result_reg  <= '0;
      op_reg      <= OP_ADD;
      cnt_reg     <= '0;
      cbit_reg    <= 1'b0;
      carry_reg   <= 1'b0;
      illegal_reg <= 1'b0;
    end else begin
      illegal_reg <= illegal_start;
      if (accept) begin
        a_sh_reg <= a;
        b_sh_reg <= b;
        op_reg   <= opcode;
        cnt_reg  <= '0;
        cbit_reg <= (opcode == OP_ADDC) ? carry_reg : 1'b0;
      end else if (state_reg == SEQ_RUN) begin
        a_sh_reg <= a_sh_reg >> 1;
        b_sh_reg <= b_sh_reg >> 1;
        r_sh_reg <= r_sh_next;
        cbit_reg <= alu_cout;
        if (!last_bit) cnt_reg <= cnt_reg + CNT_W'(1);
        if (last_bit) begin
          result_reg <= r_sh_next;
          if (op_is_arith(op_reg)) carry_reg <= alu_cout;
        end
      end
    end
  end

`ifdef SERIAL_ALU_FLAGS_EN
  logic zero_reg, ovf_reg;

  // On the last bit the operand shifters hold the original MSBs in bit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_reg <= 1'b0;
      ovf_reg  <= 1'b0;
    end else if (!accept && (state_reg == SEQ_RUN) && last_bit) begin
      zero_reg <= (r_sh_next == '0);
      ovf_reg  <= op_is_arith(op_reg) && (a_sh_reg[0] == b_sh_reg[0]) &&
                  (alu_res != a_sh_reg[0]);
    end
  end

  assign zero = zero_reg;
  assign ovf  = ovf_reg;
`endif

  assign result  = result_reg;
  assign carry   = carry_reg;
  assign illegal = illegal_reg;

endmodule
